ysyx_22041207_wb_stage: RTL and testbench
=========================================

// Module: ysyx_22041207_wb_stage
// PURPOSE
//   Registered, parametrised writeback stage: last pipeline stage before the integer register file.
//   Accepts one instruction per cycle from MEM via valid/ready and picks the writeback source.
//   Waits for late load data, aligns and extends it, then drives the regfile write port and forwarding bus.
//   Successor to the combinational writeback mux; adds XLEN parametrisation, load formatting, pipelining and a load-wait FSM.
// PARAMETERS
//   XLEN      64   datapath width; legal values 32 or 64
//   RF_AW     5    register index width
// PORTS
//   clk         in   1      clock; all state updates on rising edge
//   rst         in   1      reset, synchronous, active-high
//   in_valid    in   1      MEM stage presents an instruction
//   in_ready    out  1      stage can accept this cycle
//   in_pc       in   XLEN   instruction PC
//   in_alu_c    in   XLEN   ALU result; low 3 bits are the load byte offset
//   in_imm      in   XLEN   immediate
//   in_csr      in   XLEN   CSR read value
//   in_wd_sel   in   3      0 ALU, 1 LOAD, 2 PC+4, 3 IMM, 4 ALU word sign-extended, 5 CSR, 6/7 zero
//   in_ld_fmt   in   3      load funct3: LB 0, LH 1, LW 2, LD 3, LBU 4, LHU 5, LWU 6
//   in_rd       in   RF_AW  destination register
//   in_rd_wen   in   1      instruction writes rd
//   mem_rvalid  in   1      load data beat valid
//   mem_rdata   in   XLEN   raw aligned-doubleword (or word) read data
//   rf_wen      out  1      regfile write enable
//   rf_waddr    out  RF_AW  regfile write index
//   rf_wdata    out  XLEN   regfile write data; also the forwarding value
//   ld_pend     out  1      a load waits for data; ld_pend_rd is not forwardable yet
//   ld_pend_rd  out  RF_AW  rd of the pending load
//   instret     out  64     retired-instruction count (WB_INSTRET_EN only)
// BEHAVIOUR
//   FSM states: EMPTY, WAIT_LD, COMMIT. Reset goes to EMPTY and zeroes every output and register.
//   in_ready = (state==EMPTY) | (state==COMMIT), so COMMIT retires and accepts in the same cycle.
//   Accept when in_valid & in_ready. A non-load goes to COMMIT; its result is computed at accept and registered.
//   A load (sel 1) goes to WAIT_LD, with the byte offset and format latched.
//   WAIT_LD: when mem_rvalid=1, capture the aligned, extended data and go to COMMIT. Otherwise stay; there is no timeout.
//   mem_rvalid outside WAIT_LD is ignored and sets the sticky sim-only flag err_spur_rvalid.
//   COMMIT: rf_wen = rd_wen_q & (rd_q != 0); the entry retires. Next state is COMMIT or WAIT_LD on accept, else EMPTY.
//   Outputs are registered. rf_* are valid only in COMMIT; otherwise rf_wen=0 and waddr/wdata hold 0.
//   Latency:
//     non-load accepted in cycle N -> rf_wen in cycle N+1.
//     load with mem_rvalid in cycle M -> rf_wen in cycle M+1.
//   Back-to-back non-loads sustain 1 per cycle.
//   Arithmetic and width rules:
//     PC+4 wraps modulo 2^XLEN.
//     sel 4 gives {sext(alu_c[31:0])}. At XLEN=32 it equals alu_c.
//   Load alignment:
//     shift = offset*8, shifting mem_rdata right.
//     Byte/half/word are sign- or zero-extended per fmt.
//   Load boundary rules:
//     At XLEN=32, offset uses bits[1:0]; LD/LWU act as LW.
//     Misaligned access is not checked here; upstream traps.
//   ld_pend=1 exactly in WAIT_LD; ld_pend_rd=rd_q then, else 0.
//   Reset mid-operation: a pending load is dropped with no regfile write. A later mem_rvalid is ignored.
// CONFIGURATION
//   WB_INSTRET_EN defined: 64-bit instret counts COMMIT cycles, including rd=x0 and rd_wen=0 entries.
//     Reset clears it to 0; it wraps at 2^64.
//   WB_INSTRET_EN undefined: the instret port is absent and there is no counter logic.
// STRUCTURE
//   Package ysyx_22041207_wb_pkg holds:
//     wd_sel localparams (WB_SEL_ALU..WB_SEL_CSR);
//     load-format localparams (LD_B..LD_WU);
//     the FSM state enum typedef (wb_state_t).
//   Sub-module ysyx_22041207_ld_align: combinational (rdata, offset, fmt) -> XLEN extended value.
//   This file holds the FSM, the registers, the source mux and the optional counter.
// TESTING
//   ALU op: sel0, alu_c=0x1234, rd=5, wen=1, accepted at cycle 10 -> cycle 11: rf_wen=1, waddr=5, wdata=0x1234.
//   rd=x0: sel3, imm=0xFF, rd=0 -> COMMIT with rf_wen=0; instret increments (WB_INSTRET_EN).
//   LB offset 3: mem_rdata=0x0000_0000_8000_0000, alu_c[2:0]=3, mem_rvalid 4 cycles later.
//     ld_pend=1 for 4 cycles, in_ready=0 meanwhile.
//     wdata=0xFFFF_FFFF_FFFF_FF80.
//   LWU offset 4: mem_rdata=0x8765_4321_0000_0000 -> wdata=0x0000_0000_8765_4321.
//   Sel4 and PC+4 wrap: alu_c=0x0000_0001_8000_0000 -> 0xFFFF_FFFF_8000_0000; sel2 pc=0xFFFF_FFFF_FFFF_FFFC -> 0.
//   Reset in WAIT_LD, then mem_rvalid -> no rf_wen, state EMPTY, err_spur_rvalid=1; back-to-back ALU ops at full rate.

Source files
------------

// File: rtl/ysyx_22041207_wb_pkg.sv
// Shared definitions for the writeback stage: source-select codes,
// load-format codes and the writeback FSM state type.
package ysyx_22041207_wb_pkg;

  // Writeback data source select (in_wd_sel); codes 6/7 select zero
  localparam logic [2:0] WB_SEL_ALU  = 3'd0;
  localparam logic [2:0] WB_SEL_LOAD = 3'd1;
  localparam logic [2:0] WB_SEL_PC4  = 3'd2;
  localparam logic [2:0] WB_SEL_IMM  = 3'd3;
  localparam logic [2:0] WB_SEL_ALUW = 3'd4;
  localparam logic [2:0] WB_SEL_CSR  = 3'd5;

  // Load formats, identical to the RISC-V load funct3 encoding
  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_D  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;
  localparam logic [2:0] LD_WU = 3'd6;

  // Writeback FSM states
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_COMMIT  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/ysyx_22041207_ld_align.sv
// Load data formatter: shifts the raw doubleword (or word) right by the
// byte offset, then sign- or zero-extends the selected byte/half/word.
// At XLEN=32 only offset[1:0] matters and LD/LWU behave as LW.
module ysyx_22041207_ld_align
  import ysyx_22041207_wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] ext_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;

  // Byte-offset shift followed by width selection and extension
  always_comb begin
    shamt    = (XLEN == 64) ? {offset, 3'b000} : {1'b0, offset[1:0], 3'b000};
    shifted  = rdata >> shamt;
    ext_data = '0;
    case (fmt)
      LD_B:  ext_data = XLEN'(signed'(shifted[7:0]));
      LD_H:  ext_data = XLEN'(signed'(shifted[15:0]));
      LD_BU: ext_data = XLEN'(shifted[7:0]);
      LD_HU: ext_data = XLEN'(shifted[15:0]);
      LD_W:  ext_data = XLEN'(signed'(shifted[31:0]));
      LD_WU: begin
        if (XLEN == 64) ext_data = XLEN'(shifted[31:0]);
        else            ext_data = shifted;
      end
      LD_D:  ext_data = shifted;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041207_wb_stage.sv
// Registered writeback stage. Takes one instruction per cycle from MEM,
// selects the writeback source, waits for late load data in WAIT_LD and
// drives the regfile write port / forwarding bus from registers.
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on the instret port.
//
// Handshake: an instruction transfers on a rising edge where
// in_valid & in_ready are both 1; in_ready depends only on the current
// state (low only while waiting for load data), never on in_valid.
module ysyx_22041207_wb_stage
  import ysyx_22041207_wb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu_c,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_csr,
  input  logic [2:0]       in_wd_sel,
  input  logic [2:0]       in_ld_fmt,
  input  logic [RF_AW-1:0] in_rd,
  input  logic             in_rd_wen,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_wen,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             ld_pend,
  output logic [RF_AW-1:0] ld_pend_rd,
  output wb_state_t        dbg_state,
  output logic             err_spur_rvalid
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]      instret
`endif
);

  wb_state_t        state_q, state_d;
  logic [RF_AW-1:0] rd_q, rd_d;
  logic             rd_wen_q, rd_wen_d;
  logic [2:0]       off_q, off_d;
  logic [2:0]       fmt_q, fmt_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;

  logic             rf_wen_q, rf_wen_d;
  logic [RF_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
  logic             ld_pend_q, ld_pend_d;
  logic [RF_AW-1:0] ld_pend_rd_q, ld_pend_rd_d;
  logic             err_spur_rvalid_q, err_spur_rvalid_d;

  logic             accept;
  logic [XLEN-1:0]  src_val;
  logic [XLEN-1:0]  ld_val;

  assign in_ready = (state_q == ST_EMPTY) || (state_q == ST_COMMIT);
  assign accept   = in_valid & in_ready;

  // Formats the load beat using the offset/format latched at accept
  ysyx_22041207_ld_align #(
    .XLEN(XLEN)
  ) u_ld_align (
    .rdata   (mem_rdata),
    .offset  (off_q),
    .fmt     (fmt_q),
    .ext_data(ld_val)
  );

  // Non-load writeback source mux, evaluated on the incoming instruction
  always_comb begin
    src_val = '0;
    case (in_wd_sel)
      WB_SEL_ALU:  src_val = in_alu_c;
      WB_SEL_PC4:  src_val = in_pc + XLEN'(4);
      WB_SEL_IMM:  src_val = in_imm;
      WB_SEL_ALUW: src_val = XLEN'(signed'(in_alu_c[31:0]));
      WB_SEL_CSR:  src_val = in_csr;
      default:     src_val = '0;
    endcase
  end

  // Next-state, entry latching and next-output computation
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    rd_wen_d = rd_wen_q;
    off_d    = off_q;
    fmt_d    = fmt_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_EMPTY, ST_COMMIT: begin
        if (accept) begin
          rd_d     = in_rd;
          rd_wen_d = in_rd_wen;
          off_d    = in_alu_c[2:0];
          fmt_d    = in_ld_fmt;
          if (in_wd_sel == WB_SEL_LOAD) begin
            state_d = ST_WAIT_LD;
            wdata_d = '0;
          end else begin
            state_d = ST_COMMIT;
            wdata_d = src_val;
          end
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT_LD: begin
        if (mem_rvalid) begin
          state_d = ST_COMMIT;
          wdata_d = ld_val;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Outputs are decoded from the next state so they leave flops directly
    rf_wen_d     = (state_d == ST_COMMIT) && rd_wen_d && (rd_d != '0);
    rf_waddr_d   = (state_d == ST_COMMIT) ? rd_d : '0;
    rf_wdata_d   = (state_d == ST_COMMIT) ? wdata_d : '0;
    ld_pend_d    = (state_d == ST_WAIT_LD);
    ld_pend_rd_d = (state_d == ST_WAIT_LD) ? rd_d : '0;

    // A data beat with no load waiting is dropped and flagged (sticky)
    err_spur_rvalid_d = err_spur_rvalid_q | (mem_rvalid && (state_q != ST_WAIT_LD));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_EMPTY;
      rd_q              <= '0;
      rd_wen_q          <= 1'b0;
      off_q             <= '0;
      fmt_q             <= '0;
      wdata_q           <= '0;
      rf_wen_q          <= 1'b0;
      rf_waddr_q        <= '0;
      rf_wdata_q        <= '0;
      ld_pend_q         <= 1'b0;
      ld_pend_rd_q      <= '0;
      err_spur_rvalid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      rd_q              <= rd_d;
      rd_wen_q          <= rd_wen_d;
      off_q             <= off_d;
      fmt_q             <= fmt_d;
      wdata_q           <= wdata_d;
      rf_wen_q          <= rf_wen_d;
      rf_waddr_q        <= rf_waddr_d;
      rf_wdata_q        <= rf_wdata_d;
      ld_pend_q         <= ld_pend_d;
      ld_pend_rd_q      <= ld_pend_rd_d;
      err_spur_rvalid_q <= err_spur_rvalid_d;
    end
  end

  assign rf_wen          = rf_wen_q;
  assign rf_waddr        = rf_waddr_q;
  assign rf_wdata        = rf_wdata_q;
  assign ld_pend         = ld_pend_q;
  assign ld_pend_rd      = ld_pend_rd_q;
  assign dbg_state       = state_q;
  assign err_spur_rvalid = err_spur_rvalid_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Every COMMIT cycle retires one entry, whether or not it writes rd
  always_comb begin
    instret_d = instret_q + ((state_q == ST_COMMIT) ? 64'd1 : 64'd0);
  end

  // Retired-instruction counter register
  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_ysyx_22041207_wb_stage.sv
// Directed testbench for the writeback stage: a behavioural model checked
// every cycle, plus an expected-write queue filled with hand-computed values.
module tb_ysyx_22041207_wb_stage;
  import ysyx_22041207_wb_pkg::*;

  localparam int XLEN  = 64;
  localparam int RF_AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc, in_alu_c, in_imm, in_csr;
  logic [2:0]       in_wd_sel, in_ld_fmt;
  logic [RF_AW-1:0] in_rd;
  logic             in_rd_wen;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;
  logic             rf_wen;
  logic [RF_AW-1:0] rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             ld_pend;
  logic [RF_AW-1:0] ld_pend_rd;
  wb_state_t        dbg_state;
  logic             err_spur_rvalid;
`ifdef WB_INSTRET_EN
  logic [63:0]      instret;
`endif

  ysyx_22041207_wb_stage #(.XLEN(XLEN), .RF_AW(RF_AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_alu_c(in_alu_c), .in_imm(in_imm), .in_csr(in_csr),
    .in_wd_sel(in_wd_sel), .in_ld_fmt(in_ld_fmt),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ld_pend(ld_pend), .ld_pend_rd(ld_pend_rd),
    .dbg_state(dbg_state), .err_spur_rvalid(err_spur_rvalid)
`ifdef WB_INSTRET_EN
    , .instret(instret)
`endif
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [68:0] exp_q[$];   // {rd, data} of every expected regfile write
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [2:0] off,
                                         input logic [2:0] fmt);
    logic [63:0] v, r;
    v = raw >> (int'(off) * 8);
    r = 64'd0;
    case (fmt)
      3'd0: begin r = v % 64'd256;        if (r >= 64'd128)        r = r - 64'd256; end
      3'd1: begin r = v % 64'd65536;      if (r >= 64'd32768)      r = r - 64'd65536; end
      3'd2: begin r = v % 64'h1_0000_0000; if (r >= 64'h8000_0000) r = r - 64'h1_0000_0000; end
      3'd3: r = v;
      3'd4: r = v % 64'd256;
      3'd5: r = v % 64'd65536;
      3'd6: r = v % 64'h1_0000_0000;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] m_src(input logic [2:0] sel, input logic [63:0] pc,
                                        input logic [63:0] alu, input logic [63:0] imm,
                                        input logic [63:0] csr);
    logic [63:0] w;
    case (sel)
      3'd0: return alu;
      3'd2: return pc + 64'd4;
      3'd3: return imm;
      3'd4: begin
        w = alu % 64'h1_0000_0000;
        if (w >= 64'h8000_0000) w = w - 64'h1_0000_0000;
        return w;
      end
      3'd5: return csr;
      default: return 64'd0;
    endcase
  endfunction

  // phase: 0 = nothing held, 1 = load waiting for data, 2 = result being written
  int          m_phase = 0;
  logic [4:0]  m_rd = '0;
  logic        m_wen = 1'b0;
  logic [63:0] m_val = '0;
  logic [2:0]  m_off = '0, m_fmt = '0;
  logic        m_err = 1'b0;
  logic [63:0] m_instret = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_rd = '0; m_wen = 1'b0; m_val = '0; m_err = 1'b0; m_instret = '0;
      check_en = 1'b1;
    end else begin
      if (m_phase == 2) m_instret = m_instret + 64'd1;
      if (mem_rvalid && m_phase != 1) m_err = 1'b1;
      if (m_phase == 1) begin
        if (mem_rvalid) begin
          m_val   = m_load(mem_rdata, m_off, m_fmt);
          m_phase = 2;
        end
      end else if (in_valid) begin
        m_rd  = in_rd;
        m_wen = in_rd_wen;
        if (in_wd_sel == 3'd1) begin
          m_phase = 1;
          m_off   = in_alu_c[2:0];
          m_fmt   = in_ld_fmt;
        end else begin
          m_phase = 2;
          m_val   = m_src(in_wd_sel, in_pc, in_alu_c, in_imm, in_csr);
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("rf_wen", 64'(rf_wen), 64'(m_phase == 2 && m_wen && m_rd != 5'd0));
      chk("rf_waddr", 64'(rf_waddr), (m_phase == 2) ? 64'(m_rd) : 64'd0);
      chk("rf_wdata", rf_wdata, (m_phase == 2) ? m_val : 64'd0);
      chk("ld_pend", 64'(ld_pend), 64'(m_phase == 1));
      chk("ld_pend_rd", 64'(ld_pend_rd), (m_phase == 1) ? 64'(m_rd) : 64'd0);
      chk("in_ready", 64'(in_ready), 64'(m_phase != 1));
      chk("err_spur_rvalid", 64'(err_spur_rvalid), 64'(m_err));
`ifdef WB_INSTRET_EN
      chk("instret", instret, m_instret);
`endif
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got write rd=%0d data=%h expected no write", rf_waddr, rf_wdata);
        end else begin
          logic [68:0] e;
          e = exp_q.pop_front();
          chk("wb_q_addr", 64'(rf_waddr), 64'(e[68:64]));
          chk("wb_q_data", rf_wdata, e[63:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one instruction and holds it until it transfers
  task automatic send(input logic [2:0] sel, input logic [63:0] pc, input logic [63:0] alu,
                      input logic [63:0] imm, input logic [63:0] csr, input logic [2:0] fmt,
                      input logic [4:0] rd, input logic wen, output int waited);
    logic r;
    in_valid = 1'b1; in_wd_sel = sel; in_pc = pc; in_alu_c = alu; in_imm = imm;
    in_csr = csr; in_ld_fmt = fmt; in_rd = rd; in_rd_wen = wen;
    waited = 0;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 20) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no in_ready in %0d cycles expected acceptance", waited);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [2:0] sel, input logic [63:0] pc, input logic [63:0] alu,
                    input logic [63:0] imm, input logic [63:0] csr, input logic [4:0] rd,
                    input logic wen, input logic [63:0] expv, output int waited);
    send(sel, pc, alu, imm, csr, 3'd0, rd, wen, waited);
    if (wen && rd != 5'd0) exp_q.push_back({rd, expv});
  endtask

  // Load with `gap` idle wait cycles before the data beat arrives
  task automatic load_op(input logic [2:0] fmt, input logic [2:0] off, input logic [63:0] raw,
                         input logic [4:0] rd, input int gap, input logic [63:0] expv);
    int w, pend_cnt, nrdy_cnt;
    pend_cnt = 0; nrdy_cnt = 0;
    send(3'd1, 64'h0, 64'h8000_1000 | 64'(off), 64'h0, 64'h0, fmt, rd, 1'b1, w);
    repeat (gap) begin
      @(negedge clk);
      if (ld_pend) pend_cnt++;
      if (!in_ready) nrdy_cnt++;
      @(posedge clk);
      #1;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = raw;
    if (rd != 5'd0) exp_q.push_back({rd, expv});
    @(negedge clk);
    if (ld_pend) pend_cnt++;
    if (!in_ready) nrdy_cnt++;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk("ld_pend_cycles", 64'(pend_cnt), 64'(gap + 1));
    chk("ready_low_cycles", 64'(nrdy_cnt), 64'(gap + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w, total;
    in_valid = 1'b0; in_pc = '0; in_alu_c = '0; in_imm = '0; in_csr = '0;
    in_wd_sel = '0; in_ld_fmt = '0; in_rd = '0; in_rd_wen = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;

    idle(3);
    @(negedge clk);
    chk("reset_rf_wen", 64'(rf_wen), 64'd0);
    chk("reset_wdata", rf_wdata, 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_state", 64'(dbg_state), 64'(ST_EMPTY));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // ALU result: write appears the cycle after acceptance
    op(3'd0, 64'h0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 64'h1234, w);
    @(negedge clk);
    chk("alu_lat_wen", 64'(rf_wen), 64'd1);
    chk("alu_lat_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_lat_wdata", rf_wdata, 64'h1234);
    idle(1);

    // rd = x0 commits without a regfile write
    op(3'd3, 64'h0, 64'h0, 64'hFF, 64'h0, 5'd0, 1'b1, 64'hFF, w);
    @(negedge clk);
    chk("x0_no_write", 64'(rf_wen), 64'd0);
    idle(1);

    // Loads: offsets, widths, extension
    load_op(3'd0, 3'd3, 64'h0000_0000_8000_0000, 5'd7, 3, 64'hFFFF_FFFF_FFFF_FF80);
    load_op(3'd6, 3'd4, 64'h8765_4321_0000_0000, 5'd8, 1, 64'h0000_0000_8765_4321);
    load_op(3'd1, 3'd2, 64'h0000_0000_8001_0000, 5'd14, 0, 64'hFFFF_FFFF_FFFF_8001);
    load_op(3'd5, 3'd6, 64'hABCD_0000_0000_0000, 5'd15, 2, 64'h0000_0000_0000_ABCD);
    load_op(3'd4, 3'd7, 64'hFE00_0000_0000_0000, 5'd16, 0, 64'h0000_0000_0000_00FE);
    load_op(3'd2, 3'd4, 64'hF000_0000_1234_5678, 5'd17, 1, 64'hFFFF_FFFF_F000_0000);
    load_op(3'd3, 3'd0, 64'h0123_4567_89AB_CDEF, 5'd18, 0, 64'h0123_4567_89AB_CDEF);
    // Load retiring while the next instruction is accepted
    op(3'd5, 64'h0, 64'h0, 64'h0, 64'hDEAD, 5'd11, 1'b1, 64'hDEAD, w);
    chk("commit_accept_stall", 64'(w), 64'd0);
    idle(1);

    // Word sign-extension, PC+4 wrap, zero select, rd_wen=0
    op(3'd4, 64'h0, 64'h0000_0001_8000_0000, 64'h0, 64'h0, 5'd9, 1'b1, 64'hFFFF_FFFF_8000_0000, w);
    op(3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 64'h0, 5'd10, 1'b1, 64'h0, w);
    op(3'd6, 64'h0, 64'h55, 64'h66, 64'h77, 5'd12, 1'b1, 64'h0, w);
    op(3'd0, 64'h0, 64'h99, 64'h0, 64'h0, 5'd13, 1'b0, 64'h0, w);
    idle(2);

    // Reset while a load waits: no write, late beat is spurious
    send(3'd1, 64'h0, 64'h0, 64'h0, 64'h0, 3'd3, 5'd20, 1'b1, w);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    idle(1);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_drop_state", 64'(dbg_state), 64'(ST_EMPTY));
    chk("rst_drop_err", 64'(err_spur_rvalid), 64'd1);
    chk("rst_drop_wen", 64'(rf_wen), 64'd0);
    idle(1);

    // Back-to-back ALU ops at one per cycle
    total = 0;
    for (int i = 0; i < 4; i++) begin
      op(3'd0, 64'h0, 64'h100 + 64'(i), 64'h0, 64'h0, 5'(i + 1), 1'b1, 64'h100 + 64'(i), w);
      total += w;
    end
    chk("b2b_stalls", 64'(total), 64'd0);
    idle(4);

    chk("wb_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on simulated time
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
